// File: rtl/reg_bank_ab.sv
// 32 x XLEN register bank with latched A/B operand registers for the multicycle datapath.
// Optional build macro REG_BYPASS_EN forwards a same-cycle write onto the read ports.
module reg_bank_ab #(
  parameter int               XLEN    = 64,
  parameter logic [XLEN-1:0]  SP_INIT = 64'h0000_0000_0000_03FC
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [4:0]      RS1,
  input  logic [4:0]      RS2,
  input  logic [4:0]      RD,
  input  logic            BANCO_WIRE,
  input  logic [XLEN-1:0] WRITE_DATA,
  input  logic            LOAD_A,
  input  logic            LOAD_B,
  output logic [XLEN-1:0] READ_A,
  output logic [XLEN-1:0] READ_B,
  output logic [XLEN-1:0] REG_A_OUT,
  output logic [XLEN-1:0] REG_B_OUT
);

  logic [XLEN-1:0] regs [32];
  logic            wr_en;
  logic            fwd_a;
  logic            fwd_b;

  assign wr_en = BANCO_WIRE && (RD != 5'd0);

`ifdef REG_BYPASS_EN
  assign fwd_a = wr_en && (RD == RS1);
  assign fwd_b = wr_en && (RD == RS2);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // x0 is forced to zero at the port so no forwarding or stored value can leak through.
  always_comb begin
    READ_A = '0;
    if (RS1 != 5'd0) READ_A = fwd_a ? WRITE_DATA : regs[RS1];
  end

  always_comb begin
    READ_B = '0;
    if (RS2 != 5'd0) READ_B = fwd_b ? WRITE_DATA : regs[RS2];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 2) ? SP_INIT : '0;
      REG_A_OUT <= '0;
      REG_B_OUT <= '0;
    end else begin
      if (wr_en) regs[RD] <= WRITE_DATA;
      if (LOAD_A) REG_A_OUT <= READ_A;
      if (LOAD_B) REG_B_OUT <= READ_B;
    end
  end

endmodule

// File: tb/tb_reg_bank_ab.sv
// Self-checking bench for reg_bank_ab: directed scenarios plus randomized traffic
// compared against an array-based model of the register file.
module tb_reg_bank_ab;
  localparam logic [63:0] SP = 64'h0000_0000_0000_03FC;
`ifdef REG_BYPASS_EN
  localparam bit          BYP = 1'b1;
  localparam logic [63:0] HAZ = 64'd20;
`else
  localparam bit          BYP = 1'b0;
  localparam logic [63:0] HAZ = 64'd10;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [4:0]  RS1 = '0, RS2 = '0, RD = '0;
  logic        BANCO_WIRE = 1'b0, LOAD_A = 1'b0, LOAD_B = 1'b0;
  logic [63:0] WRITE_DATA = '0;
  logic [63:0] READ_A, READ_B, REG_A_OUT, REG_B_OUT;

  reg_bank_ab #(.XLEN(64), .SP_INIT(SP)) dut (
    .CLK(CLK), .RESET(RESET), .RS1(RS1), .RS2(RS2), .RD(RD),
    .BANCO_WIRE(BANCO_WIRE), .WRITE_DATA(WRITE_DATA),
    .LOAD_A(LOAD_A), .LOAD_B(LOAD_B),
    .READ_A(READ_A), .READ_B(READ_B),
    .REG_A_OUT(REG_A_OUT), .REG_B_OUT(REG_B_OUT)
  );

  always #5 CLK = ~CLK;

  logic [63:0] mem [32];
  logic [63:0] ma, mb;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    if (BYP && BANCO_WIRE && RD != 5'd0 && RD == idx) return WRITE_DATA;
    return mem[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[2] = SP;
    ma = '0;
    mb = '0;
  endtask

  task automatic drive(input bit we, input logic [4:0] rd, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input bit la, input bit lb);
    BANCO_WIRE = we; RD = rd; WRITE_DATA = wd;
    RS1 = r1; RS2 = r2; LOAD_A = la; LOAD_B = lb;
  endtask

  // One clock: check comb reads, advance the model, clock, check latches and reads.
  task automatic cycle();
    logic [63:0] na, nb;
    #1;
    chk("read_a_pre", READ_A, mread(RS1));
    chk("read_b_pre", READ_B, mread(RS2));
    na = LOAD_A ? mread(RS1) : ma;
    nb = LOAD_B ? mread(RS2) : mb;
    if (BANCO_WIRE && RD != 5'd0) mem[RD] = WRITE_DATA;
    ma = na;
    mb = nb;
    @(posedge CLK);
    #1;
    chk("reg_a_out", REG_A_OUT, ma);
    chk("reg_b_out", REG_B_OUT, mb);
    chk("read_a_post", READ_A, mread(RS1));
    chk("read_b_post", READ_B, mread(RS2));
  endtask

  initial begin
    logic [4:0] rd;
    model_reset();
    #12;
    chk("init_reg_a", REG_A_OUT, 64'd0);
    RS1 = 5'd2;
    #1 chk("init_x2", READ_A, SP);
    @(negedge CLK) RESET = 1'b0;

    // write then read/latch x5
    drive(1, 5'd5, 64'hDEAD_BEEF_0000_0005, 5'd0, 5'd0, 0, 0); cycle();
    drive(0, 5'd0, 64'd0, 5'd5, 5'd5, 1, 1); cycle();
    chk("x5_latch_a", REG_A_OUT, 64'hDEAD_BEEF_0000_0005);
    chk("x5_latch_b", REG_B_OUT, 64'hDEAD_BEEF_0000_0005);

    // x0 protection
    drive(1, 5'd0, '1, 5'd0, 5'd0, 0, 0); cycle();
    drive(0, 5'd0, 64'd0, 5'd0, 5'd0, 1, 0); cycle();
    chk("x0_read", READ_A, 64'd0);
    chk("x0_latch", REG_A_OUT, 64'd0);

    // same-edge write/load hazard
    drive(1, 5'd7, 64'd10, 5'd0, 5'd0, 0, 0); cycle();
    drive(1, 5'd7, 64'd20, 5'd7, 5'd0, 1, 0); cycle();
    chk("hazard_latch", REG_A_OUT, HAZ);
    drive(0, 5'd0, 64'd0, 5'd7, 5'd0, 0, 0);
    #1 chk("x7_after", READ_A, 64'd20);

    // hold and independence
    drive(1, 5'd3, 64'd3, 5'd0, 5'd0, 0, 0); cycle();
    drive(1, 5'd4, 64'd4, 5'd0, 5'd0, 0, 0); cycle();
    drive(0, 5'd0, 64'd0, 5'd3, 5'd4, 1, 1); cycle();
    drive(1, 5'd3, 64'd99, 5'd5, 5'd6, 0, 0); cycle();
    chk("hold_a", REG_A_OUT, 64'd3);
    chk("hold_b", REG_B_OUT, 64'd4);
    chk("follow_a", READ_A, 64'hDEAD_BEEF_0000_0005);
    drive(0, 5'd0, 64'd0, 5'd3, 5'd0, 0, 0);
    #1 chk("x3_new", READ_A, 64'd99);

    // randomized traffic, biased toward read/write index collisions
    for (int n = 0; n < 400; n++) begin
      rd = 5'($urandom_range(31));
      drive(($urandom_range(1) == 1), rd, {$urandom, $urandom},
            ($urandom_range(3) == 0) ? rd : 5'($urandom_range(31)),
            ($urandom_range(3) == 0) ? rd : 5'($urandom_range(31)),
            ($urandom_range(1) == 1), ($urandom_range(1) == 1));
      cycle();
    end

    // asynchronous reset mid-cycle, then sweep every index
    drive(0, 5'd0, 64'd0, 5'd0, 5'd0, 0, 0);
    #2 RESET = 1'b1;
    model_reset();
    #1;
    chk("rst_reg_a", REG_A_OUT, 64'd0);
    chk("rst_reg_b", REG_B_OUT, 64'd0);
    for (int i = 0; i < 32; i++) begin
      RS1 = 5'(i);
      RS2 = 5'(31 - i);
      #1;
      chk("rst_read_a", READ_A, mem[i]);
      chk("rst_read_b", READ_B, mem[31 - i]);
    end
    @(negedge CLK) RESET = 1'b0;

    // reset coincident with a write to x9
    @(negedge CLK);
    drive(1, 5'd9, 64'd1, 5'd9, 5'd9, 0, 0);
    #2 RESET = 1'b1;
    @(posedge CLK);
    #1 BANCO_WIRE = 1'b0;
    #1 chk("x9_after_rst", READ_A, 64'd0);
    @(negedge CLK) RESET = 1'b0;
    model_reset();
    drive(1, 5'd9, 64'd1, 5'd9, 5'd9, 0, 0); cycle();
    BANCO_WIRE = 1'b0;
    #1 chk("x9_first_write", READ_A, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
